systolic_mm_ctrl: RTL
=====================

// Module: systolic_mm_ctrl
// PURPOSE
// Parametrised sequencing controller for the NxN systolic matrix multiplier. Streams both
// operand matrices from ROM/RAM into the accelerator register banks, compensates memory
// read latency, runs the MAC phase and sequences result write-back. Adds start/busy/done
// handshake, abort, and latency-aligned bank loading.
// PARAMETERS
// N       4  matrix dimension; power of 2, >=2
// ADDR_W  4  ROM/RAM/store address width; 2**ADDR_W >= N*N
// RD_LAT  2  memory read latency in cycles, 1..4
// CNT_W   8  phase counter width; 2**CNT_W > max(N*N, 3N-2)
// PORTS
// clk          in   1                clock, rising edge
// reset        in   1                asynchronous, active-high
// enable       in   1                global clock enable; 0 freezes all state and outputs
// start        in   1                run request; accepted only in IDLE with enable=1
// abort        in   1                synchronous abort; returns to IDLE, no done pulse
// busy         out  1                high in every state except IDLE
// done         out  1                one-cycle pulse at end of STORE
// count        out  CNT_W            cycle count within current phase
// read_en      out  1                ROM/RAM read strobe
// rom_address  out  ADDR_W           operand-A read address
// ram_address  out  ADDR_W           operand-B read address
// load_en      out  1                register-bank capture strobe, read_en delayed RD_LAT
// bank_sel     out  $clog2(N)        target bank (row) for captured element
// elem_sel     out  $clog2(N)        target element within bank
// acc_clr      out  1                clear array accumulators
// mac_en       out  1                systolic array advance
// st_en        out  1                result write strobe
// st_addr      out  ADDR_W           result write address
// BEHAVIOUR
// - Reset: state IDLE, every output 0, read-latency pipeline cleared, immediately (no edge).
// - All outputs registered. enable=0: no state, counter, address or pipeline change.
// - States: IDLE, READ, DRAIN, MAC, STORE, DONE. Cycle 1 = first cycle after start accepted.
// - IDLE: start&enable -> READ. start in any other state ignored (no restart, no queue).
// - READ, cycles 1..N*N: read_en=1, rom_address=ram_address=k-1 in cycle k; acc_clr=1 in
//   cycle 1 only. After last address -> DRAIN; addresses return to 0.
// - load_en/bank_sel/elem_sel: RD_LAT-deep shift of read_en and element index e;
//   bank_sel=e/N, elem_sel=e%N; load_en high cycles 1+RD_LAT..N*N+RD_LAT.
// - DRAIN: RD_LAT cycles, read_en=0, pipeline empties -> MAC.
// - MAC: mac_en=1 for exactly 3N-2 cycles -> STORE.
// - STORE: N*N cycles, st_en=1, st_addr 0..N*N-1 ascending -> DONE; st_addr returns to 0.
// - DONE: one cycle, done=1, busy=1 -> IDLE. Done cycle = 2*N*N+RD_LAT+3N-1 (45 at defaults).
// - count: 0 on every state entry, +1 per enabled cycle; never wraps within a phase.
// - abort (enable=1, non-IDLE): next state IDLE; read_en/load_en/mac_en/st_en/acc_clr
//   drop to 0, pipeline flushed, addresses 0, no done. abort and phase end together: abort wins.
// - Addresses never wrap: max value N*N-1.
// TESTING
// 1 defaults, start pulse -> rom/ram 0..15 cycles 1-16; load_en 3-18, (bank,elem) (0,0)..(3,3);
//   mac_en 19-28; st_addr 0..15 cycles 29-44; done single pulse cycle 45; busy 0 cycle 46.
// 2 enable=0 for 3 cycles while rom_address=5 -> all outputs frozen, resumes at 6, done at 48.
// 3 start during MAC and in the DONE cycle -> ignored; start one cycle later in IDLE -> full run.
// 4 abort while st_addr=7 -> IDLE next cycle, st_en=0, no done; new start restarts at address 0.
// 5 reset asserted mid-MAC between edges -> mac_en, busy, count, addresses 0 with no clock edge.
// 6 N=8, RD_LAT=3, ADDR_W=6 -> read_en 64 cycles, load_en 4-67, mac_en 22 cycles, done at 154.

Source files
------------

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for an NxN systolic matrix multiplier: operand streaming with read-latency
// alignment, MAC phase, result write-back, and a start/busy/done/abort handshake.
module systolic_mm_ctrl #(
  parameter int N      = 4,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       count,
  output logic                   read_en,
  output logic [ADDR_W-1:0]      rom_address,
  output logic [ADDR_W-1:0]      ram_address,
  output logic                   load_en,
  output logic [$clog2(N)-1:0]   bank_sel,
  output logic [$clog2(N)-1:0]   elem_sel,
  output logic                   acc_clr,
  output logic                   mac_en,
  output logic                   st_en,
  output logic [ADDR_W-1:0]      st_addr
);

  localparam int LN    = $clog2(N);
  localparam int IDX_W = 2 * LN;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] ELEM_LAST  = CNT_W'(N * N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] MAC_LAST   = CNT_W'(3 * N - 3);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              read_en_q, read_en_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              acc_clr_q, acc_clr_d;
  logic              mac_en_q, mac_en_d;
  logic              st_en_q, st_en_d;
  logic [ADDR_W-1:0] st_addr_q, st_addr_d;
  logic              abort_take;

  // Read-latency alignment: stage i holds the strobe/element issued i cycles ago.
  logic [RD_LAT:1]            vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:1][IDX_W-1:0] idx_pipe_q, idx_pipe_d;

  assign abort_take = abort && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    count_d = count_q + 1'b1;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (count_q == ELEM_LAST)  state_d = S_DRAIN;
      S_DRAIN: if (count_q == DRAIN_LAST) state_d = S_MAC;
      S_MAC:   if (count_q == MAC_LAST)   state_d = S_STORE;
      S_STORE: if (count_q == ELEM_LAST)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort overrides any phase-end transition
    if (abort_take) state_d = S_IDLE;
    if (state_d != state_q || state_d == S_IDLE) count_d = '0;
  end

  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    read_en_d     = (state_d == S_READ);
    rom_address_d = read_en_d ? ADDR_W'(count_d) : '0;
    acc_clr_d     = read_en_d && (count_d == '0);
    mac_en_d      = (state_d == S_MAC);
    st_en_d       = (state_d == S_STORE);
    st_addr_d     = st_en_d ? ADDR_W'(count_d) : '0;
  end

  always_comb begin
    vld_pipe_d    = '0;
    idx_pipe_d    = '0;
    vld_pipe_d[1] = read_en_q;
    idx_pipe_d[1] = rom_address_q[IDX_W-1:0];
    for (int i = 2; i <= RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      idx_pipe_d[i] = idx_pipe_q[i-1];
    end
    if (abort_take) begin
      vld_pipe_d = '0;
      idx_pipe_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      read_en_q     <= 1'b0;
      rom_address_q <= '0;
      acc_clr_q     <= 1'b0;
      mac_en_q      <= 1'b0;
      st_en_q       <= 1'b0;
      st_addr_q     <= '0;
      vld_pipe_q    <= '0;
      idx_pipe_q    <= '0;
    end else if (enable) begin
      state_q       <= state_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      read_en_q     <= read_en_d;
      rom_address_q <= rom_address_d;
      acc_clr_q     <= acc_clr_d;
      mac_en_q      <= mac_en_d;
      st_en_q       <= st_en_d;
      st_addr_q     <= st_addr_d;
      vld_pipe_q    <= vld_pipe_d;
      idx_pipe_q    <= idx_pipe_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign count       = count_q;
  assign read_en     = read_en_q;
  assign rom_address = rom_address_q;
  assign ram_address = rom_address_q;
  assign acc_clr     = acc_clr_q;
  assign mac_en      = mac_en_q;
  assign st_en       = st_en_q;
  assign st_addr     = st_addr_q;
  assign load_en     = vld_pipe_q[RD_LAT];
  assign bank_sel    = idx_pipe_q[RD_LAT][IDX_W-1:LN];
  assign elem_sel    = idx_pipe_q[RD_LAT][LN-1:0];

endmodule
